reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 137 +++++++++++++
 tb/tb_reset_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for a stable synchronised PLL lock, then
// releases the staged reset outputs one at a time and supervises for lock loss.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 75000,
  parameter int STAGE_GAP   = 16,
  parameter int NUM_STAGES  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  sw_reset,
  output logic [NUM_STAGES-1:0] reset_stage,
  output logic                  ready,
  output logic [7:0]            lock_loss_count
);

  typedef enum logic [1:0] {WAIT_LOCK, STABILISE, RELEASE, RUN} state_t;

  localparam int                IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [19:0]       HOLD_LAST = 20'(HOLD_CYCLES - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  state_t                  state_reg, state_next;
  logic                    locked_meta_reg, locked_s_reg;
  logic [19:0]             hold_reg, hold_next;
  logic [7:0]              gap_reg, gap_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [NUM_STAGES-1:0]   stage_reg, stage_next;
  logic                    ready_reg, ready_next;
  logic [7:0]              loss_reg, loss_next;
  logic [NUM_STAGES-1:0]   stage_sel;

  // One-hot select of the stage bit addressed by the release index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
      assign stage_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      locked_meta_reg <= 1'b0;
      locked_s_reg    <= 1'b0;
      state_reg       <= WAIT_LOCK;
      hold_reg        <= '0;
      gap_reg         <= '0;
      idx_reg         <= '0;
      stage_reg       <= '1;
      ready_reg       <= 1'b0;
      loss_reg        <= '0;
    end else begin
      locked_meta_reg <= locked;
      locked_s_reg    <= locked_meta_reg;
      state_reg       <= state_next;
      hold_reg        <= hold_next;
      gap_reg         <= gap_next;
      idx_reg         <= idx_next;
      stage_reg       <= stage_next;
      ready_reg       <= ready_next;
      loss_reg        <= loss_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    gap_next   = gap_reg;
    idx_next   = idx_reg;
    stage_next = stage_reg;
    ready_next = ready_reg;
    loss_next  = loss_reg;
    case (state_reg)
      WAIT_LOCK: begin
        stage_next = '1;
        ready_next = 1'b0;
        if (locked_s_reg) begin
          state_next = STABILISE;
          hold_next  = '0;
        end
      end
      STABILISE: begin
        if (!locked_s_reg) begin
          state_next = WAIT_LOCK;
        end else if (hold_reg == HOLD_LAST) begin
          state_next = RELEASE;
          gap_next   = '0;
          idx_next   = '0;
        end else begin
          hold_next = hold_reg + 20'd1;
        end
      end
      RELEASE: begin
        if (!locked_s_reg) begin
          state_next = WAIT_LOCK;
          stage_next = '1;
          ready_next = 1'b0;
        end else if (gap_reg == GAP_LAST) begin
          stage_next = stage_reg & ~stage_sel;
          gap_next   = '0;
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = RUN;
            ready_next = 1'b1;
          end
        end else begin
          gap_next = gap_reg + 8'd1;
        end
      end
      RUN: begin
        // Lock loss has priority over a simultaneous soft reset request.
        if (!locked_s_reg) begin
          state_next = WAIT_LOCK;
          stage_next = '1;
          ready_next = 1'b0;
          if (loss_reg != 8'hFF) loss_next = loss_reg + 8'd1;
        end else if (sw_reset) begin
          state_next = STABILISE;
          hold_next  = '0;
          stage_next = '1;
          ready_next = 1'b0;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        stage_next = '1;
        ready_next = 1'b0;
      end
    endcase
  end

  assign reset_stage     = stage_reg;
  assign ready           = ready_reg;
  assign lock_loss_count = loss_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       locked = 1'b0;
  logic       sw_reset = 1'b0;
  logic [2:0] reset_stage;
  logic       ready;
  logic [7:0] lock_loss_count;

  int checks = 0;
  int failures = 0;

  reset_sequencer #(
    .HOLD_CYCLES(8),
    .STAGE_GAP  (4),
    .NUM_STAGES (3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .locked         (locked),
    .sw_reset       (sw_reset),
    .reset_stage    (reset_stage),
    .ready          (ready),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks edges from_edge..22 of a release sequence (edge 0 samples locked high).
  task automatic check_release(input int from_edge, input string tag);
    logic [2:0] exp;
    for (int e = from_edge; e <= 22; e++) begin
      tick();
      exp = (e < 14) ? 3'b111 : (e < 18) ? 3'b110 : (e < 22) ? 3'b100 : 3'b000;
      chk($sformatf("%s_stage_e%0d", tag, e), 32'(reset_stage), 32'(exp));
      chk($sformatf("%s_ready_e%0d", tag, e), 32'(ready), (e >= 22) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int exp_count;
    int waited;

    // Asynchronous reset assertion before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_stage", 32'(reset_stage), 32'h7);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_count", 32'(lock_loss_count), 32'h0);
    $display("step reset_async stage=%b ready=%b count=%0d", reset_stage, ready, lock_loss_count);
    tick(); tick();
    reset = 1'b0;

    // Short lock pulse must never reach RELEASE.
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("pulse_stage_%0d", i), 32'(reset_stage), 32'h7);
      chk($sformatf("pulse_ready_%0d", i), 32'(ready), 32'h0);
    end
    chk("pulse_count", 32'(lock_loss_count), 32'h0);
    $display("step short_pulse stage=%b count=%0d", reset_stage, lock_loss_count);

    // Power-up release timing.
    locked = 1'b1;
    check_release(0, "pwr");
    $display("step power_up stage=%b ready=%b", reset_stage, ready);

    // Soft reset from RUN.
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    chk("sw_stage_k0", 32'(reset_stage), 32'h7);
    chk("sw_ready_k0", 32'(ready), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sw_stage_k%0d", k), 32'(reset_stage),
          (k < 12) ? 32'h7 : (k < 16) ? 32'h6 : (k < 20) ? 32'h4 : 32'h0);
      chk($sformatf("sw_ready_k%0d", k), 32'(ready), (k >= 20) ? 32'd1 : 32'd0);
    end
    chk("sw_count", 32'(lock_loss_count), 32'h0);
    $display("step sw_reset stage=%b ready=%b count=%0d", reset_stage, ready, lock_loss_count);

    // One-cycle lock drop in RUN.
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    chk("loss_stage", 32'(reset_stage), 32'h7);
    chk("loss_ready", 32'(ready), 32'h0);
    chk("loss_count", 32'(lock_loss_count), 32'h1);
    check_release(2, "loss");
    $display("step lock_drop stage=%b ready=%b count=%0d", reset_stage, ready, lock_loss_count);

    // Repeated lock losses saturate the counter.
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      tick(); tick(); tick();
      exp_count = (i + 2 > 255) ? 255 : i + 2;
      chk($sformatf("sat_count_%0d", i), 32'(lock_loss_count), 32'(exp_count));
      chk($sformatf("sat_stage_%0d", i), 32'(reset_stage), 32'h7);
      locked = 1'b1;
      waited = 0;
      while (ready !== 1'b1 && waited < 40) begin
        tick();
        waited++;
      end
      chk($sformatf("sat_ready_%0d", i), 32'(ready), 32'h1);
    end
    $display("step saturate count=%0d", lock_loss_count);

    // Async reset mid-RELEASE clears everything before the next edge.
    locked = 1'b0;
    tick(); tick(); tick();
    chk("mid_count_hold", 32'(lock_loss_count), 32'd255);
    locked = 1'b1;
    repeat (15) tick();
    chk("mid_stage_110", 32'(reset_stage), 32'h6);
    chk("mid_ready_0", 32'(ready), 32'h0);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_stage", 32'(reset_stage), 32'h7);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    chk("mid_rst_count", 32'(lock_loss_count), 32'h0);
    $display("step mid_release_reset stage=%b ready=%b count=%0d", reset_stage, ready, lock_loss_count);
    tick(); tick();
    chk("mid_rst_hold_stage", 32'(reset_stage), 32'h7);
    reset = 1'b0;

    // Sequence restarts cleanly after reset with locked already high.
    check_release(0, "post");
    chk("post_count", 32'(lock_loss_count), 32'h0);
    $display("step post_reset stage=%b ready=%b count=%0d", reset_stage, ready, lock_loss_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
